// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline skid stage: occupancy states and the zero payload.
package pipe_stage_skid_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_state_e;

   localparam int unsigned PAYLOAD_MAX_W = 1024;
   localparam logic [PAYLOAD_MAX_W-1:0] PAYLOAD_ZERO = '0;

   localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_stage_skid_sat_counter
   import pipe_stage_skid_pkg::*;
#(
   parameter int W = STALL_CNT_W
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: 2-entry skid buffer (registered in_ready) or single
// register with pass-through ready, plus a saturating downstream-stall counter.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int DW         = 64,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [15:0]   stall_cnt
);

   localparam logic [DW-1:0] ZERO = PAYLOAD_ZERO[DW-1:0];

   stage_state_e  state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_xfer;
   logic          out_xfer;
   logic          stall_inc;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign stall_inc = out_valid && !out_ready;

   // Flush beats transfers; a same-cycle output transfer is still delivered downstream.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         if (CLEAR_DATA != 0) begin
            main_d = ZERO;
            skid_d = ZERO;
         end
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d = ST_FULL;
                  main_d  = in_data;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end else if (in_xfer && (SKID != 0)) begin
                  state_d = ST_SKID;
                  skid_d  = in_data;
               end
            end
            ST_SKID: begin
               if (out_xfer) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= ZERO;
         skid_q  <= ZERO;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Skid mode registers ready from the next state so upstream never sees out_ready.
   if (SKID != 0) begin : g_skid_ready
      logic in_ready_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            in_ready_q <= 1'b1;
         end else begin
            in_ready_q <= (state_d != ST_SKID);
         end
      end
      assign in_ready = in_ready_q;
   end else begin : g_pass_ready
      assign in_ready = out_ready || !out_valid;
   end

   assign out_data = ((CLEAR_DATA != 0) && !out_valid) ? ZERO : main_q;

   pipe_stage_skid_sat_counter #(
      .W (16)
   ) u_stall_cnt (
      .clk   (clk),
      .clr_i (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised-stream bench for pipe_stage_skid in skid (index 1) and pass-through (index 0) modes.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush     [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [63:0] in_data   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [63:0] out_data  [2];
   logic [15:0] stall_cnt [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DW(64), .SKID(1), .CLEAR_DATA(1)) u_dut_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_data  (out_data[1]),
      .stall_cnt (stall_cnt[1])
   );

   pipe_stage_skid #(.DW(64), .SKID(0), .CLEAR_DATA(1)) u_dut_pass (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_data  (out_data[0]),
      .stall_cnt (stall_cnt[0])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int m);
      logic [63:0] q[$];
      logic [63:0] exp;
      int sent = 0;
      int rcvd = 0;
      int cyc  = 0;
      while (rcvd < 1000 && cyc < 20000) begin
         in_valid[m]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data[m]   = {8'hC0, 8'(m), 16'h0000, 32'(sent)};
         out_ready[m] = ($urandom_range(0, 1) == 1);
         #1;
         if (out_valid[m] && out_ready[m]) begin
            exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            check("stream_data", out_data[m], exp);
            rcvd++;
         end
         if (in_valid[m] && in_ready[m]) begin
            q.push_back(in_data[m]);
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid[m]  = 1'b0;
      out_ready[m] = 1'b0;
      check("stream_count", 64'(rcvd), 64'd1000);
      check("stream_left", 64'(q.size()), 64'd0);
   endtask

   localparam logic [63:0] PAY_A = 64'h0000_0100_0000_0013;
   localparam logic [63:0] PAY_B = 64'h1111_2222_3333_4444;
   localparam logic [63:0] PAY_C = 64'hAAAA_0000_0000_000C;
   localparam logic [63:0] PAY_D = 64'hAAAA_0000_0000_000D;
   localparam logic [63:0] PAY_E = 64'hAAAA_0000_0000_000E;
   localparam logic [63:0] PAY_F = 64'hAAAA_0000_0000_000F;
   localparam logic [63:0] PAY_K = 64'h5A5A_A5A5_0F0F_F0F0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         flush[i]     = 1'b0;
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b0;
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid[1]), 64'd0);
      check("rst_out_data", out_data[1], 64'd0);
      check("rst_in_ready", 64'(in_ready[1]), 64'd1);
      check("rst_stall", 64'(stall_cnt[1]), 64'd0);
      check("rst_in_ready_pass", 64'(in_ready[0]), 64'd1);

      // First transfer: one-cycle latency into an empty stage
      in_valid[1] = 1'b1; in_data[1] = PAY_A; out_ready[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      check("lat_out_valid", 64'(out_valid[1]), 64'd1);
      check("lat_out_data", out_data[1], PAY_A);
      check("lat_in_ready", 64'(in_ready[1]), 64'd1);
      tick();
      check("drain_out_valid", 64'(out_valid[1]), 64'd0);
      check("drain_out_data", out_data[1], 64'd0);

      // Fill both entries while downstream is blocked
      out_ready[1] = 1'b0;
      in_valid[1] = 1'b1; in_data[1] = PAY_A;
      tick();
      check("fill_a_in_ready", 64'(in_ready[1]), 64'd1);
      in_data[1] = PAY_B;
      tick();
      in_valid[1] = 1'b0;
      check("skid_in_ready", 64'(in_ready[1]), 64'd0);
      check("skid_out_data", out_data[1], PAY_A);
      check("skid_out_valid", 64'(out_valid[1]), 64'd1);
      check("skid_stall", 64'(stall_cnt[1]), 64'd1);
      out_ready[1] = 1'b1;
      tick();
      check("after_a_out_data", out_data[1], PAY_B);
      check("after_a_in_ready", 64'(in_ready[1]), 64'd1);
      tick();
      check("after_b_out_valid", 64'(out_valid[1]), 64'd0);

      // Flush from the skid state with a competing input
      out_ready[1] = 1'b0;
      in_valid[1] = 1'b1; in_data[1] = PAY_C;
      tick();
      in_data[1] = PAY_D;
      tick();
      check("pre_flush_in_ready", 64'(in_ready[1]), 64'd0);
      flush[1] = 1'b1; in_data[1] = PAY_E;
      tick();
      flush[1] = 1'b0; in_valid[1] = 1'b0;
      check("flush_out_valid", 64'(out_valid[1]), 64'd0);
      check("flush_out_data", out_data[1], 64'd0);
      check("flush_in_ready", 64'(in_ready[1]), 64'd1);
      check("flush_keeps_stall", 64'(stall_cnt[1]), 64'd3);
      out_ready[1] = 1'b1;
      tick();
      check("post_flush_empty", 64'(out_valid[1]), 64'd0);
      in_valid[1] = 1'b1; in_data[1] = PAY_F;
      tick();
      in_valid[1] = 1'b0;
      check("post_flush_data", out_data[1], PAY_F);
      tick();

      // Input accepted in the same cycle as a flush is dropped
      in_valid[1] = 1'b1; in_data[1] = PAY_C; flush[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0; flush[1] = 1'b0;
      check("flush_drop_in", 64'(out_valid[1]), 64'd0);

      // Reset mid-operation discards the entry and clears the stall count
      out_ready[1] = 1'b0;
      in_valid[1] = 1'b1; in_data[1] = PAY_D;
      tick();
      in_valid[1] = 1'b0;
      tick();
      check("pre_rst_stall", 64'(stall_cnt[1]), 64'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid[1]), 64'd0);
      check("midrst_stall", 64'(stall_cnt[1]), 64'd0);
      check("midrst_in_ready", 64'(in_ready[1]), 64'd1);

      // Long stall saturates the counter; flush leaves it alone
      in_valid[1] = 1'b1; in_data[1] = PAY_K;
      tick();
      in_valid[1] = 1'b0;
      for (int i = 0; i < 70000; i++) tick();
      check("sat_stall", 64'(stall_cnt[1]), 64'h0000_0000_0000_FFFF);
      check("sat_out_data", out_data[1], PAY_K);
      flush[1] = 1'b1;
      tick();
      flush[1] = 1'b0;
      check("sat_after_flush", 64'(stall_cnt[1]), 64'h0000_0000_0000_FFFF);
      check("sat_flush_valid", 64'(out_valid[1]), 64'd0);

      // Pass-through mode: ready follows out_ready combinationally
      in_valid[0] = 1'b1; in_data[0] = PAY_B; out_ready[0] = 1'b0;
      #1;
      check("pass_empty_ready", 64'(in_ready[0]), 64'd1);
      tick();
      in_valid[0] = 1'b0;
      #1;
      check("pass_full_blocked", 64'(in_ready[0]), 64'd0);
      check("pass_out_data", out_data[0], PAY_B);
      out_ready[0] = 1'b1;
      #1;
      check("pass_ready_hi", 64'(in_ready[0]), 64'd1);
      out_ready[0] = 1'b0;
      #1;
      check("pass_ready_lo", 64'(in_ready[0]), 64'd0);
      in_valid[0] = 1'b1; in_data[0] = PAY_C; out_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      check("pass_replace_data", out_data[0], PAY_C);
      check("pass_replace_valid", 64'(out_valid[0]), 64'd1);
      tick();
      check("pass_drained", 64'(out_valid[0]), 64'd0);

      stream(1);
      stream(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
